// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port: fetch requester, data requester and memory side.
// The arbiter takes the slave view; the environment (requesters plus memory) takes the master view.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to fetch or data (data first, with a fetch starvation guard),
// runs the req/ack handshake and aborts with bus_err when the memory never acknowledges.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam logic [3:0]  STARVE_L  = 4'(STARVE_LIMIT);
  localparam logic [10:0] TIMEOUT_L = 11'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [9:0]  wait_q, wait_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        bus_err_q, bus_err_d;

  logic        timeout_hit;
  logic        done;
  logic [31:0] rdata_sel;

  // The abort fires on the edge that would bring the wait count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((11'(wait_q) + 11'd1) == TIMEOUT_L);
  assign done        = bus.mem_ack || timeout_hit;
  assign rdata_sel   = bus.mem_ack ? bus.mem_rdata : 32'd0;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.d_req && ((starve_q < STARVE_L) || !bus.if_req)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wait_d      = '0;
          if (bus.if_req && (starve_q < STARVE_L)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (bus.if_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          wait_d      = '0;
          starve_d    = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (done) begin
          // An ack on the timeout edge still counts as a normal completion.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = !bus.mem_ack;
          if (state_q == BUSY_I) begin
            if_ready_d = 1'b1;
            if_rdata_d = rdata_sel;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = rdata_sel;
            end
          end
        end else begin
          wait_d = wait_q + 10'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and responses are queued by the
// stimulus and popped by an independent monitor whenever the DUT raises mem_req or a ready.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic is_d; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;

  rsp_t exp_rsp[$];
  gnt_t exp_gnt[$];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int last_req_len = 0;
  logic        ack_disable = 1'b0;
  logic        inject_ack  = 1'b0;
  logic [31:0] rd_val = 32'd0;
  int          mem_wait = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_gnt(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    gnt_t g;
    g.we = we; g.addr = addr; g.wdata = wdata;
    exp_gnt.push_back(g);
  endtask

  task automatic push_rsp(input logic is_d, input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.is_d = is_d; r.rdata = rdata; r.err = err;
    exp_rsp.push_back(r);
  endtask

  // Memory model: acks after mem_wait cycles of mem_req, or never when ack_disable is set.
  initial begin : mem_model
    int wcnt;
    wcnt = 0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      if (inject_ack) begin
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'hBAD0_BAD0;
      end else if (bus_if.mem_req && !ack_disable) begin
        if (wcnt >= mem_wait) begin
          bus_if.mem_ack   = 1'b1;
          bus_if.mem_rdata = rd_val;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin : monitor
    rsp_t r;
    gnt_t g;
    logic prev_req;
    int   cur_len;
    prev_req = 1'b0;
    cur_len  = 0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_req && !prev_req) begin
        cur_len = 1;
        if (exp_gnt.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_grant: addr 0x%08h, no grant expected", bus_if.mem_addr);
        end else begin
          g = exp_gnt.pop_front();
          check("gnt_we", 32'(bus_if.mem_we), 32'(g.we));
          check("gnt_addr", bus_if.mem_addr, g.addr);
          if (g.we) check("gnt_wdata", bus_if.mem_wdata, g.wdata);
        end
      end else if (bus_if.mem_req) begin
        cur_len++;
      end else if (prev_req) begin
        last_req_len = cur_len;
      end
      prev_req = bus_if.mem_req;

      if (bus_if.if_ready || bus_if.d_ready) begin
        if (exp_rsp.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_ready: if_ready %0b d_ready %0b, none expected",
                   bus_if.if_ready, bus_if.d_ready);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_if_ready", 32'(bus_if.if_ready), 32'(!r.is_d));
          check("rsp_d_ready", 32'(bus_if.d_ready), 32'(r.is_d));
          check("rsp_rdata", r.is_d ? bus_if.d_rdata : bus_if.if_rdata, r.rdata);
          check("rsp_bus_err", 32'(bus_if.bus_err), 32'(r.err));
        end
      end else if (bus_if.bus_err) begin
        nvec++; nerr++;
        $display("FAIL stray_bus_err: got 1 expected 0 without ready");
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr, output int lat);
    int t0;
    bit seen;
    t0 = cyc;
    seen = 1'b0;
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = addr;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.if_ready) seen = 1'b1;
    end
    bus_if.if_req = 1'b0;
    lat = cyc - t0;
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL fetch_wait: no if_ready for 0x%08h within 200 cycles", addr);
    end
  endtask

  // Issues n back-to-back data requests, presenting the next one together with ready.
  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int n, output int lat);
    int t0;
    int k;
    t0 = cyc;
    k = 0;
    lat = 0;
    bus_if.d_req   = 1'b1;
    bus_if.d_we    = we;
    bus_if.d_addr  = addr;
    bus_if.d_wdata = wdata;
    for (int i = 0; i < 400 && k < n; i++) begin
      @(negedge clk);
      if (bus_if.d_ready) begin
        if (k == 0) lat = cyc - t0;
        k++;
        bus_if.d_addr  = addr + 32'(4 * k);
        bus_if.d_wdata = wdata + 32'(k);
      end
    end
    bus_if.d_req = 1'b0;
    if (k < n) begin
      nvec++; nerr++;
      $display("FAIL data_wait: %0d of %0d data completions seen", k, n);
    end
  endtask

  initial begin : stim
    int lat_i;
    int lat_d;
    bus_if.if_req  = 1'b0;
    bus_if.if_addr = 32'd0;
    bus_if.d_req   = 1'b0;
    bus_if.d_we    = 1'b0;
    bus_if.d_addr  = 32'd0;
    bus_if.d_wdata = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("rst_if_ready", 32'(bus_if.if_ready), 32'd0);
    check("rst_d_ready", 32'(bus_if.d_ready), 32'd0);
    check("rst_bus_err", 32'(bus_if.bus_err), 32'd0);
    check("rst_mem_addr", bus_if.mem_addr, 32'd0);
    check("rst_if_rdata", bus_if.if_rdata, 32'd0);
    check("rst_d_rdata", bus_if.d_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, zero-wait memory.
    rd_val = 32'h0000_0013;
    push_gnt(1'b0, 32'h0000_0100, 32'd0);
    push_rsp(1'b0, 32'h0000_0013, 1'b0);
    do_fetch(32'h0000_0100, lat_i);
    check("fetch_latency", 32'(lat_i), 32'd2);
    @(negedge clk);
    check("fetch_req_len", 32'(last_req_len), 32'd1);

    // Simultaneous store and fetch: data wins, store leaves d_rdata alone.
    rd_val = 32'h0040_0093;
    push_gnt(1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
    push_gnt(1'b0, 32'h0000_0104, 32'd0);
    push_rsp(1'b1, 32'h0000_0000, 1'b0);
    push_rsp(1'b0, 32'h0040_0093, 1'b0);
    fork
      do_data(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1, lat_d);
      do_fetch(32'h0000_0104, lat_i);
    join
    check("simul_fetch_latency", 32'(lat_i), 32'd4);
    @(negedge clk);

    // Load with three wait states.
    mem_wait = 3;
    rd_val = 32'h1234_5678;
    push_gnt(1'b0, 32'h0000_3000, 32'd0);
    push_rsp(1'b1, 32'h1234_5678, 1'b0);
    do_data(1'b0, 32'h0000_3000, 32'd0, 1, lat_d);
    check("wait_latency", 32'(lat_d), 32'd5);
    mem_wait = 0;

    // Stray ack while idle must not disturb anything.
    @(posedge clk);
    inject_ack = 1'b1;
    @(posedge clk);
    inject_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_if_ready", 32'(bus_if.if_ready), 32'd0);
    check("idle_ack_d_ready", 32'(bus_if.d_ready), 32'd0);
    check("idle_ack_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("idle_ack_d_rdata", bus_if.d_rdata, 32'h1234_5678);
    check("idle_ack_if_rdata", bus_if.if_rdata, 32'h0040_0093);

    // Timeout on a load.
    ack_disable = 1'b1;
    push_gnt(1'b0, 32'h0000_0040, 32'd0);
    push_rsp(1'b1, 32'h0000_0000, 1'b1);
    do_data(1'b0, 32'h0000_0040, 32'd0, 1, lat_d);
    check("timeout_latency", 32'(lat_d), 32'(TIMEOUT + 1));
    @(negedge clk);
    check("timeout_req_len", 32'(last_req_len), 32'(TIMEOUT));
    check("timeout_mem_req", 32'(bus_if.mem_req), 32'd0);
    ack_disable = 1'b0;

    // Starvation guard: four data grants, one fetch, then data resumes.
    rd_val = 32'h00C0_0113;
    for (int k = 0; k < 4; k++) begin
      push_gnt(1'b1, 32'h0000_2100 + 32'(4 * k), 32'h5000_0000 + 32'(k));
      push_rsp(1'b1, 32'h0000_0000, 1'b0);
    end
    push_gnt(1'b0, 32'h0000_0600, 32'd0);
    push_rsp(1'b0, 32'h00C0_0113, 1'b0);
    for (int k = 4; k < 6; k++) begin
      push_gnt(1'b1, 32'h0000_2100 + 32'(4 * k), 32'h5000_0000 + 32'(k));
      push_rsp(1'b1, 32'h0000_0000, 1'b0);
    end
    fork
      do_data(1'b1, 32'h0000_2100, 32'h5000_0000, 6, lat_d);
      do_fetch(32'h0000_0600, lat_i);
    join
    check("starve_fetch_latency", 32'(lat_i), 32'd10);
    @(negedge clk);

    // Asynchronous reset in the middle of a fetch.
    ack_disable = 1'b1;
    push_gnt(1'b0, 32'h0000_0500, 32'd0);
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 32'h0000_0500;
    repeat (3) @(negedge clk);
    check("busy_mem_req", 32'(bus_if.mem_req), 32'd1);
    bus_if.if_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("arst_if_ready", 32'(bus_if.if_ready), 32'd0);
    check("arst_mem_addr", bus_if.mem_addr, 32'd0);
    check("arst_if_rdata", bus_if.if_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_disable = 1'b0;
    @(negedge clk);
    rd_val = 32'h00A0_0093;
    push_gnt(1'b0, 32'h0000_0504, 32'd0);
    push_rsp(1'b0, 32'h00A0_0093, 1'b0);
    do_fetch(32'h0000_0504, lat_i);
    check("post_rst_latency", 32'(lat_i), 32'd2);

    repeat (3) @(negedge clk);
    check("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
